// File: rtl/tone_decoder_pkg.sv
// -----------------------------------------------------------------------------
// tone_decoder_pkg
// Shared types and constants for the tone decoder slice:
//   - note_e       : confirmed-note code (0 none, 1 Do, 2 Bb, 3 Sol)
//   - seq_state_e  : jingle sequence FSM states
//   - nominal_hp / win_lo / win_hi : derive the nominal half-period of a tone
//     and its +/-1% acceptance window (integer cycles) from the clock rate.
// -----------------------------------------------------------------------------
package tone_decoder_pkg;

  localparam int unsigned HP_W = 32'd20;
  localparam logic [HP_W-1:0] HP_MAX = {HP_W{1'b1}};

  localparam int unsigned DO_HZ  = 32'd523;
  localparam int unsigned BB_HZ  = 32'd466;
  localparam int unsigned SOL_HZ = 32'd392;

  typedef enum logic [1:0] {
    NOTE_NONE = 2'd0,
    NOTE_DO   = 2'd1,
    NOTE_BB   = 2'd2,
    NOTE_SOL  = 2'd3
  } note_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GOT_DO = 2'd1,
    ST_GOT_BB = 2'd2
  } seq_state_e;

  // Half-period of a square wave of tone_hz, in clock cycles (truncated).
  function automatic longint unsigned nominal_hp(input longint unsigned clk_hz,
                                                 input longint unsigned tone_hz);
    return clk_hz / (64'd2 * tone_hz);
  endfunction

  // Lower window bound: floor(nom * 0.99).
  function automatic longint unsigned win_lo(input longint unsigned nom);
    return (nom * 64'd99) / 64'd100;
  endfunction

  // Upper window bound: ceil(nom * 1.01).
  function automatic longint unsigned win_hi(input longint unsigned nom);
    return (nom * 64'd101 + 64'd99) / 64'd100;
  endfunction

  // Nominals at the default 100 MHz clock (95_602 / 107_296 / 127_551).
  localparam longint unsigned DO_NOM_100M  = nominal_hp(64'd100_000_000, 64'(DO_HZ));
  localparam longint unsigned BB_NOM_100M  = nominal_hp(64'd100_000_000, 64'(BB_HZ));
  localparam longint unsigned SOL_NOM_100M = nominal_hp(64'd100_000_000, 64'(SOL_HZ));

endpackage

// File: rtl/tone_decoder_if.sv
// -----------------------------------------------------------------------------
// tone_decoder_if
// Bundles the tone input and the decoder result signals.
//   buzz_in     : asynchronous square-wave tone input
//   note_code   : confirmed note (note_e encoding)
//   note_valid  : note_code is nonzero
//   note_strobe : one-cycle pulse on a newly confirmed note
//   seq_done    : one-cycle pulse when Do, Bb, Sol completes
//   half_period : last measured edge-to-edge interval (cycles, saturating)
// master = tone source / observer, slave = decoder.
// -----------------------------------------------------------------------------
interface tone_decoder_if;
  import tone_decoder_pkg::*;

  logic            buzz_in;
  logic [1:0]      note_code;
  logic            note_valid;
  logic            note_strobe;
  logic            seq_done;
  logic [HP_W-1:0] half_period;

  modport master (
    output buzz_in,
    input  note_code, note_valid, note_strobe, seq_done, half_period
  );

  modport slave (
    input  buzz_in,
    output note_code, note_valid, note_strobe, seq_done, half_period
  );
endinterface

// File: rtl/tone_decoder_period_meter.sv
// -----------------------------------------------------------------------------
// period_meter
// Synchronizes the tone input, detects edges of either polarity and measures
// the number of cycles between consecutive edges.
//   clk, reset  : system clock, async active-low reset
//   buzz_in     : asynchronous tone input
//   edge_pulse  : one-cycle pulse, registered on the cycle an edge is seen
//   interval    : cycles since the previous edge, loaded with edge_pulse
//   silence     : one-cycle pulse when the counter first reaches SILENCE_CYC
// -----------------------------------------------------------------------------
module period_meter
  import tone_decoder_pkg::*;
#(
  parameter int unsigned SILENCE_CYC = 32'd262_144
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            buzz_in,
  output logic            edge_pulse,
  output logic [HP_W-1:0] interval,
  output logic            silence
);

  localparam logic [HP_W-1:0] SIL_LIM = HP_W'(SILENCE_CYC);

  logic            sync1_r;
  logic            sync2_r;
  logic            sync2_d_r;
  logic            edge_s;
  logic [HP_W-1:0] cnt_r;
  logic [HP_W-1:0] cnt_inc_s;
  logic            edge_r;
  logic [HP_W-1:0] interval_r;
  logic            silence_r;

  // Two-flop synchronizer plus one delay flop for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r   <= 1'b0;
      sync2_r   <= 1'b0;
      sync2_d_r <= 1'b0;
    end else begin
      sync1_r   <= buzz_in;
      sync2_r   <= sync1_r;
      sync2_d_r <= sync2_r;
    end
  end

  assign edge_s = sync2_r ^ sync2_d_r;

  // Saturating increment of the interval counter.
  always_comb begin
    cnt_inc_s = cnt_r;
    if (cnt_r == HP_MAX) begin
      cnt_inc_s = cnt_r;
    end else begin
      cnt_inc_s = cnt_r + HP_W'(1);
    end
  end

  // Interval counter, captured interval and silence detection. An edge wins
  // over a silence timeout in the same cycle because it restarts the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r      <= {HP_W{1'b0}};
      edge_r     <= 1'b0;
      interval_r <= {HP_W{1'b0}};
      silence_r  <= 1'b0;
    end else if (edge_s) begin
      cnt_r      <= HP_W'(1);
      edge_r     <= 1'b1;
      interval_r <= cnt_r;
      silence_r  <= 1'b0;
    end else begin
      cnt_r      <= cnt_inc_s;
      edge_r     <= 1'b0;
      interval_r <= interval_r;
      // Fire once when the count arrives at the limit, not while parked there.
      silence_r  <= (cnt_inc_s == SIL_LIM) && (cnt_r != SIL_LIM);
    end
  end

  assign edge_pulse = edge_r;
  assign interval   = interval_r;
  assign silence    = silence_r;

endmodule

// File: rtl/tone_decoder.sv
// -----------------------------------------------------------------------------
// tone_decoder
// Recognises Do (523 Hz), Bb (466 Hz) and Sol (392 Hz) on a buzzer line and
// flags the Do-Bb-Sol jingle.
//   clk   : system clock (CLK_HZ)
//   reset : asynchronous active-low reset
//   bus   : tone_decoder_if.slave (buzz_in in; note/sequence results out)
// Each measured half-period is classified against a +/-1% window. CONFIRM_N
// consecutive same-class intervals confirm a note; a confirmed note is held
// through glitch intervals and only cleared by silence or reset.
// -----------------------------------------------------------------------------
module tone_decoder
  import tone_decoder_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 32'd100_000_000,
  parameter int unsigned CONFIRM_N   = 32'd4,
  parameter int unsigned SILENCE_CYC = 32'd262_144
) (
  input  logic    clk,
  input  logic    reset,
  tone_decoder_if.slave bus
);

  localparam logic [HP_W-1:0] DO_LO  = HP_W'(win_lo(nominal_hp(64'(CLK_HZ), 64'(DO_HZ))));
  localparam logic [HP_W-1:0] DO_HI  = HP_W'(win_hi(nominal_hp(64'(CLK_HZ), 64'(DO_HZ))));
  localparam logic [HP_W-1:0] BB_LO  = HP_W'(win_lo(nominal_hp(64'(CLK_HZ), 64'(BB_HZ))));
  localparam logic [HP_W-1:0] BB_HI  = HP_W'(win_hi(nominal_hp(64'(CLK_HZ), 64'(BB_HZ))));
  localparam logic [HP_W-1:0] SOL_LO = HP_W'(win_lo(nominal_hp(64'(CLK_HZ), 64'(SOL_HZ))));
  localparam logic [HP_W-1:0] SOL_HI = HP_W'(win_hi(nominal_hp(64'(CLK_HZ), 64'(SOL_HZ))));

  localparam int unsigned        MATCH_W = $clog2(CONFIRM_N + 32'd1);
  localparam logic [MATCH_W-1:0] CONF    = MATCH_W'(CONFIRM_N);
  localparam logic [MATCH_W-1:0] ONE     = MATCH_W'(1);

  logic               edge_s;
  logic [HP_W-1:0]    interval_s;
  logic               silence_s;
  note_e              cls_s;
  logic [MATCH_W-1:0] match_nxt_s;
  logic               confirm_s;
  seq_state_e         state_nxt_s;
  logic               seq_done_nxt_s;

  note_e              note_code_r;
  note_e              prev_cls_r;
  logic [MATCH_W-1:0] match_r;
  logic               note_strobe_r;
  seq_state_e         state_r;
  logic               seq_done_r;

  period_meter #(.SILENCE_CYC(SILENCE_CYC)) u_meter (
    .clk        (clk),
    .reset      (reset),
    .buzz_in    (bus.buzz_in),
    .edge_pulse (edge_s),
    .interval   (interval_s),
    .silence    (silence_s)
  );

  // Map an interval onto a note class; windows do not overlap.
  function automatic note_e classify(input logic [HP_W-1:0] iv);
    note_e c;
    if ((iv >= DO_LO) && (iv <= DO_HI)) begin
      c = NOTE_DO;
    end else if ((iv >= BB_LO) && (iv <= BB_HI)) begin
      c = NOTE_BB;
    end else if ((iv >= SOL_LO) && (iv <= SOL_HI)) begin
      c = NOTE_SOL;
    end else begin
      c = NOTE_NONE;
    end
    return c;
  endfunction

  // Classification, run-length of matching classes and confirmation.
  always_comb begin
    cls_s       = classify(interval_s);
    match_nxt_s = {MATCH_W{1'b0}};
    if (cls_s == NOTE_NONE) begin
      match_nxt_s = {MATCH_W{1'b0}};
    end else if (cls_s == prev_cls_r) begin
      // Saturate so a long held note never wraps back through CONF.
      if (match_r == CONF) begin
        match_nxt_s = match_r;
      end else begin
        match_nxt_s = match_r + ONE;
      end
    end else begin
      match_nxt_s = ONE;
    end
    confirm_s = (match_nxt_s == CONF) && (cls_s != note_code_r);
  end

  // Note tracking: update on each edge, clear all history on silence.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      note_code_r   <= NOTE_NONE;
      prev_cls_r    <= NOTE_NONE;
      match_r       <= {MATCH_W{1'b0}};
      note_strobe_r <= 1'b0;
    end else if (edge_s) begin
      prev_cls_r    <= cls_s;
      match_r       <= match_nxt_s;
      note_strobe_r <= confirm_s;
      if (confirm_s) begin
        note_code_r <= cls_s;
      end else begin
        note_code_r <= note_code_r;
      end
    end else if (silence_s) begin
      note_code_r   <= NOTE_NONE;
      prev_cls_r    <= NOTE_NONE;
      match_r       <= {MATCH_W{1'b0}};
      note_strobe_r <= 1'b0;
    end else begin
      note_strobe_r <= 1'b0;
    end
  end

  // Sequence FSM next state; it only moves on a note strobe.
  always_comb begin
    state_nxt_s    = state_r;
    seq_done_nxt_s = 1'b0;
    if (silence_s) begin
      state_nxt_s = ST_IDLE;
    end else if (note_strobe_r) begin
      case (state_r)
        ST_IDLE: begin
          if (note_code_r == NOTE_DO) begin
            state_nxt_s = ST_GOT_DO;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_GOT_DO: begin
          case (note_code_r)
            NOTE_BB: state_nxt_s = ST_GOT_BB;
            NOTE_DO: state_nxt_s = ST_GOT_DO;
            default: state_nxt_s = ST_IDLE;
          endcase
        end
        ST_GOT_BB: begin
          case (note_code_r)
            NOTE_SOL: begin
              state_nxt_s    = ST_IDLE;
              seq_done_nxt_s = 1'b1;
            end
            NOTE_DO: state_nxt_s = ST_GOT_DO;
            default: state_nxt_s = ST_IDLE;
          endcase
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Sequence FSM state register; seq_done lands the cycle after the strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      seq_done_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      seq_done_r <= seq_done_nxt_s;
    end
  end

  assign bus.note_code   = note_code_r;
  assign bus.note_valid  = (note_code_r != NOTE_NONE);
  assign bus.note_strobe = note_strobe_r;
  assign bus.seq_done    = seq_done_r;
  assign bus.half_period = interval_s;

endmodule

// File: doc/tone_decoder.md
TONE_DECODER -- requirements
Module: tone_decoder

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter CONFIRM_N, default 4, consecutive matching half-periods needed to confirm a note.
REQ-003 Parameter SILENCE_CYC, default 262_144, cycles without an input edge before silence is declared.
REQ-004 Port clk, input, 1, single system clock, rising edge.
REQ-005 Port reset, input, 1, asynchronous active-low reset.
REQ-006 Port buzz_in, input, 1, asynchronous square-wave tone input (buzzer drive line).
REQ-007 Port note_code, output, 2, confirmed note: 0 none, 1 Do (523 Hz), 2 Bb (466 Hz), 3 Sol (392 Hz).
REQ-008 Port note_valid, output, 1, high while note_code is nonzero.
REQ-009 Port note_strobe, output, 1, one-cycle pulse when a note is newly confirmed.
REQ-010 Port seq_done, output, 1, one-cycle pulse when the Do, Bb, Sol sequence completes.
REQ-011 Port half_period, output, 20, last measured edge-to-edge interval in cycles, saturating.

Function
REQ-012 buzz_in SHALL pass a 2-flop synchronizer; edges (either polarity) are detected on the synchronized signal, giving 3 cycles of input-to-edge latency.
REQ-013 A 20-bit interval counter SHALL count cycles since the last edge, saturate at 2^20-1, and restart at 1 on each edge.
REQ-014 On each edge, half_period SHALL load the counter value on the next cycle.
REQ-015 Each interval SHALL be classified by window: nominal half-period = CLK_HZ/(2*f); accept within ±1% (integer bounds, package constants); no match = class 0.
REQ-016 At 100 MHz nominals: Do 95_602, Bb 107_296, Sol 127_551 cycles.
REQ-017 A match counter SHALL increment when the class equals the previous interval's nonzero class; otherwise it restarts at 1 (matching class) or 0 (class 0).
REQ-018 When the match counter reaches CONFIRM_N with class c != note_code, note_code SHALL become c and note_strobe SHALL pulse in the same cycle.
REQ-019 Reaching CONFIRM_N with c == note_code SHALL produce no strobe; the note stays held.
REQ-020 A class-0 interval SHALL reset the match counter but SHALL NOT clear note_code (glitch at note boundary).
REQ-021 When the interval counter reaches SILENCE_CYC, note_code SHALL go to 0, the match counter SHALL clear, and the sequence FSM SHALL return to IDLE; the next note confirmed after silence strobes even if it equals the previous note.
REQ-022 Sequence FSM states: IDLE, GOT_DO, GOT_BB; it advances only on note_strobe.
REQ-023 IDLE: Do -> GOT_DO; any other note -> IDLE.
REQ-024 GOT_DO: Bb -> GOT_BB; Do -> GOT_DO; Sol -> IDLE.
REQ-025 GOT_BB: Sol -> pulse seq_done the cycle after the strobe, then IDLE; Do -> GOT_DO; Bb is unreachable.
REQ-026 If a silence timeout and an edge occur in the same cycle, the edge SHALL take precedence and silence is not declared.

Reset
REQ-027 While reset is low: all outputs 0, synchronizer flops 0, counters 0, FSM IDLE; release takes effect on the first clk edge after deassertion.
REQ-028 Reset asserted mid-note or mid-sequence SHALL abandon all history; no strobe or seq_done pulse is emitted afterward until a note is fully reconfirmed.

Structure
REQ-029 A shared package SHALL hold the note-code enumeration, the FSM state type, and functions/constants deriving the nominal and ±1% window bounds from CLK_HZ.
REQ-030 A single sub-module, period_meter (synchronizer, edge detect, interval counter, silence flag), SHALL be instantiated; classification and the FSM stay in tone_decoder.

Verification
REQ-031 Drive 523 Hz for 8 ms -> note_code=1; exactly one note_strobe, about 4 half-periods after the first edge; half_period within 95_602±1.
REQ-032 Drive the jingle (523, 466, 392 Hz, 800_001 cycles each) -> three strobes with codes 1, 2, 3, then one seq_done pulse.
REQ-033 Drive 440 Hz (113_636 cycles) -> note_code stays 0, no strobe, half_period=113_636±1.
REQ-034 Drive Do, stop input for 300_000 cycles, drive Do again -> note_code=0 at SILENCE_CYC, second strobe on reconfirm, no seq_done.
REQ-035 Drive Do then Sol -> FSM back to IDLE, no seq_done.
REQ-036 Drive Do then Bb, pulse reset low for 10 cycles, drive Sol -> note_code=3, no seq_done.
